// File: rtl/ghash_accum.sv
// GHASH accumulator: Y <- (Y ^ X) * H in GF(2^128) mod x^128 + x^7 + x^2 + x + 1.
// Drives an external carry-less multiplier and folds its 256-bit product back to 128 bits.
module ghash_accum #(
  parameter int WIDTH = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   h_i,
  input  logic               h_load_i,
  input  logic               clear_i,
  input  logic               data_valid_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic               data_ready_o,
  output logic               mul_valid_o,
  output logic [WIDTH-1:0]   mul_a_o,
  output logic [WIDTH-1:0]   mul_b_o,
  input  logic               mul_valid_i,
  input  logic [2*WIDTH-1:0] mul_result_i,
  output logic [WIDTH-1:0]   y_o,
  output logic               y_valid_o,
  output logic               busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] h_reg;
  logic [WIDTH-1:0] y_reg;
  logic             accept;

  // Two folds suffice: the first leaves at most 7 overflow bits above x^127.
  function automatic logic [127:0] reduce(input logic [255:0] p);
    logic [127:0] hi;
    logic [127:0] lo;
    logic [134:0] t;
    logic [6:0]   u;
    hi = p[255:128];
    lo = p[127:0];
    t  = {7'b0, hi} ^ {6'b0, hi, 1'b0} ^ {5'b0, hi, 2'b0} ^ {hi, 7'b0};
    u  = t[134:128];
    return lo ^ t[127:0] ^ {121'b0, u} ^ {120'b0, u, 1'b0} ^ {119'b0, u, 2'b0}
           ^ {114'b0, u, 7'b0};
  endfunction

  assign data_ready_o = en & ~rst & (state == IDLE);
  assign accept       = data_valid_i & data_ready_o;
  assign y_valid_o    = (state == DONE);
  assign busy_o       = (state != IDLE);
  assign y_o          = y_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      h_reg       <= '0;
      y_reg       <= '0;
      mul_valid_o <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
    end else if (en) begin
      mul_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (h_load_i) h_reg <= h_i;
          if (clear_i)  y_reg <= '0;
          // Operands see the pre-edge H and the cleared Y when both coincide.
          if (accept) begin
            mul_a_o     <= (clear_i ? '0 : y_reg) ^ data_i;
            mul_b_o     <= h_reg;
            mul_valid_o <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (clear_i) begin
            y_reg <= '0;
            state <= mul_valid_i ? IDLE : DRAIN;
          end else if (mul_valid_i) begin
            y_reg <= reduce(mul_result_i);
            state <= DONE;
          end
        end
        DRAIN: begin
          if (mul_valid_i) state <= IDLE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_accum.sv
// Self-checking bench for ghash_accum: a latency-programmable multiplier model plus
// a bit-serial GF(2^128) reference for the expected accumulator value.
module tb_ghash_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [127:0] h_i;
  logic         h_load_i;
  logic         clear_i;
  logic         data_valid_i;
  logic [127:0] data_i;
  logic         model_valid;
  logic         spur_valid;
  logic [255:0] mul_result_i;
  wire          data_ready_o;
  wire          mul_valid_o;
  wire  [127:0] mul_a_o;
  wire  [127:0] mul_b_o;
  wire  [127:0] y_o;
  wire          y_valid_o;
  wire          busy_o;

  int vectors = 0;
  int miscompares = 0;
  int lat = 3;
  logic [127:0] ref_y = '0;
  logic [127:0] ref_h = '0;

  ghash_accum #(.WIDTH(128)) dut (
    .clk(clk), .rst(rst), .en(en), .h_i(h_i), .h_load_i(h_load_i), .clear_i(clear_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
    .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_valid_i(model_valid | spur_valid), .mul_result_i(mul_result_i),
    .y_o(y_o), .y_valid_o(y_valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] clmul(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] z;
    z = '0;
    for (int i = 0; i < 128; i++) if (b[i]) z ^= ({128'b0, a} << i);
    return z;
  endfunction

  // Shift-and-add multiply, reducing by x^128 = x^7 + x^2 + x + 1 on each doubling.
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = a;
    for (int i = 0; i < 128; i++) begin
      if (b[i]) z ^= v;
      v = v[127] ? ((v << 1) ^ 128'h87) : (v << 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Multiplier model: latches operands on an enabled strobe edge, answers lat cycles later.
  logic         m_e, m_r, m_mv;
  logic [127:0] m_a, m_b;
  logic [255:0] m_prod;
  int           m_cnt;
  initial begin
    model_valid = 1'b0;
    mul_result_i = '0;
    m_cnt = 0;
    m_prod = '0;
    forever begin
      @(negedge clk);
      #4;
      m_e = en; m_r = rst; m_mv = mul_valid_o; m_a = mul_a_o; m_b = mul_b_o;
      @(posedge clk);
      #1;
      if (m_r || rst) begin
        m_cnt = 0;
        model_valid = 1'b0;
      end else if (m_e) begin
        model_valid = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin model_valid = 1'b1; mul_result_i = m_prod; end
        end
        if (m_mv) begin
          m_prod = clmul(m_a, m_b);
          m_cnt = lat - 1;
          if (m_cnt == 0) begin model_valid = 1'b1; mul_result_i = m_prod; end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load_h(input logic [127:0] h);
    h_i = h;
    h_load_i = 1'b1;
    @(negedge clk);
    h_load_i = 1'b0;
    #1;
    ref_h = h;
  endtask

  task automatic clear_y();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    ref_y = '0;
  endtask

  // Returns one cycle after the accepting edge (the strobe cycle).
  task automatic accept_block(input logic [127:0] x, input logic clr, output logic ok);
    int n;
    n = 0;
    data_valid_i = 1'b1;
    data_i = x;
    clear_i = clr;
    #1;
    while (!data_ready_o && n < 50) begin step(); n++; end
    ok = data_ready_o;
    @(negedge clk);
    data_valid_i = 1'b0;
    clear_i = 1'b0;
    #1;
  endtask

  task automatic wait_y(output int n);
    n = 0;
    while (!y_valid_o && n < 60) begin step(); n++; end
  endtask

  task automatic process_block(input logic [127:0] x, input logic clr, output logic ok,
                               output int n, output logic [127:0] yv);
    if (clr) ref_y = '0;
    ref_y = gf_mul(ref_y ^ x, ref_h);
    accept_block(x, clr, ok);
    wait_y(n);
    yv = y_o;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; h_i = '0; h_load_i = 1'b0; clear_i = 1'b0;
    data_valid_i = 1'b0; data_i = '0; spur_valid = 1'b0;
    repeat (2) step();
    vectors++;
    if ({mul_valid_o, y_valid_o, busy_o, data_ready_o, mul_a_o, mul_b_o, y_o} !== 388'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got mv=%b yv=%b busy=%b rdy=%b a=%h b=%h y=%h want all 0",
               mul_valid_o, y_valid_o, busy_o, data_ready_o, mul_a_o, mul_b_o, y_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (data_ready_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", data_ready_o);
    end
    ref_y = '0; ref_h = '0;
  endtask

  task automatic test_identity();
    logic ok;
    int n;
    lat = 3;
    load_h(128'h1);
    ref_y = gf_mul(ref_y ^ 128'h5, ref_h);
    accept_block(128'h5, 1'b0, ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL id_accept: got %b want 1", ok); end
    vectors++;
    if ({mul_valid_o, busy_o, data_ready_o} !== 3'b110) begin
      miscompares++; $display("[TB] FAIL id_strobe: got %b want 110", {mul_valid_o, busy_o, data_ready_o});
    end
    vectors++;
    if (mul_a_o !== 128'h5) begin miscompares++; $display("[TB] FAIL id_mul_a: got %h want 5", mul_a_o); end
    vectors++;
    if (mul_b_o !== 128'h1) begin miscompares++; $display("[TB] FAIL id_mul_b: got %h want 1", mul_b_o); end
    step();
    vectors++;
    if (mul_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL id_strobe_len: got %b want 0", mul_valid_o); end
    wait_y(n);
    vectors++;
    if (n !== lat) begin miscompares++; $display("[TB] FAIL id_latency: got %0d want %0d", n + 1, lat + 1); end
    vectors++;
    if (y_o !== 128'h5 || y_o !== ref_y) begin
      miscompares++; $display("[TB] FAIL id_y: got %h want %h", y_o, ref_y);
    end
    step();
    vectors++;
    if ({y_valid_o, data_ready_o} !== 2'b01) begin
      miscompares++; $display("[TB] FAIL id_after_pulse: got yv/rdy=%b want 01", {y_valid_o, data_ready_o});
    end
  endtask

  task automatic test_reduction();
    logic ok;
    int n;
    logic [127:0] yv;
    lat = 2;
    clear_y();
    load_h(128'h1 << 127);
    process_block(128'h2, 1'b0, ok, n, yv);
    vectors++;
    if (yv !== 128'h87) begin miscompares++; $display("[TB] FAIL red_x128: got %h want 87", yv); end
    vectors++;
    if (n !== lat + 1) begin miscompares++; $display("[TB] FAIL red_latency: got %0d want %0d", n, lat + 1); end
    clear_y();
    process_block(128'h1 << 127, 1'b0, ok, n, yv);
    vectors++;
    if (yv !== ref_y) begin miscompares++; $display("[TB] FAIL red_x254: got %h want %h", yv, ref_y); end
  endtask

  task automatic test_chaining();
    logic ok;
    int n;
    logic [127:0] yv;
    lat = 1;
    clear_y();
    load_h(128'h2);
    process_block(128'h1, 1'b0, ok, n, yv);
    vectors++;
    if (yv !== 128'h2) begin miscompares++; $display("[TB] FAIL chain_x1: got %h want 2", yv); end
    process_block(128'h0, 1'b0, ok, n, yv);
    vectors++;
    if (yv !== 128'h4) begin miscompares++; $display("[TB] FAIL chain_x2: got %h want 4", yv); end
    ref_y = gf_mul(128'h1, ref_h);
    accept_block(128'h1, 1'b1, ok);
    vectors++;
    if (mul_a_o !== 128'h1) begin miscompares++; $display("[TB] FAIL chain_clear_a: got %h want 1", mul_a_o); end
    wait_y(n);
    vectors++;
    if (y_o !== 128'h2 || y_valid_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL chain_x3: got %h yv=%b want 2 yv=1", y_o, y_valid_o);
    end
    step();
  endtask

  task automatic test_abort();
    logic ok;
    int n;
    logic saw;
    logic [127:0] yv;
    lat = 4;
    clear_y();
    load_h(128'h1);
    accept_block(128'hF, 1'b0, ok);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    ref_y = '0;
    vectors++;
    if (y_o !== 128'h0) begin miscompares++; $display("[TB] FAIL abort_y: got %h want 0", y_o); end
    vectors++;
    if ({busy_o, data_ready_o, y_valid_o} !== 3'b100) begin
      miscompares++; $display("[TB] FAIL abort_drain: got busy/rdy/yv=%b want 100", {busy_o, data_ready_o, y_valid_o});
    end
    n = 0; saw = 1'b0;
    while (!data_ready_o && n < 50) begin
      if (y_valid_o) saw = 1'b1;
      step(); n++;
    end
    vectors++;
    if (n !== lat) begin miscompares++; $display("[TB] FAIL abort_ready_time: got %0d want %0d", n, lat); end
    vectors++;
    if (saw !== 1'b0 || y_o !== 128'h0) begin
      miscompares++; $display("[TB] FAIL abort_discard: got pulse=%b y=%h want 0 0", saw, y_o);
    end
    // Clear arriving in the very cycle the product returns.
    lat = 2;
    accept_block(128'h3, 1'b0, ok);
    repeat (lat) step();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    #1;
    vectors++;
    if ({y_o, y_valid_o, busy_o, data_ready_o} !== {128'h0, 3'b001}) begin
      miscompares++; $display("[TB] FAIL abort_coincide: got y=%h yv/busy/rdy=%b want 0 001",
                              y_o, {y_valid_o, busy_o, data_ready_o});
    end
    load_h(rand128());
    process_block(rand128(), 1'b0, ok, n, yv);
    vectors++;
    if (yv !== ref_y) begin miscompares++; $display("[TB] FAIL abort_recover: got %h want %h", yv, ref_y); end
  endtask

  task automatic test_stall();
    logic ok;
    int n;
    logic [127:0] x, old_y, exp_a, old_h, yv;
    logic [387:0] obs, expv;
    lat = 3;
    load_h(rand128());
    x = rand128();
    old_y = ref_y;
    exp_a = ref_y ^ x;
    ref_y = gf_mul(exp_a, ref_h);
    accept_block(x, 1'b0, ok);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {mul_valid_o, y_valid_o, busy_o, data_ready_o, mul_a_o, mul_b_o, y_o};
      expv = {4'b1010, exp_a, ref_h, old_y};
      vectors++;
      if (obs !== expv) begin
        miscompares++; $display("[TB] FAIL stall_freeze_%0d: got %h want %h", i, obs, expv);
      end
    end
    en = 1'b1;
    wait_y(n);
    vectors++;
    if (y_valid_o !== 1'b1 || y_o !== ref_y) begin
      miscompares++; $display("[TB] FAIL stall_result: got %h yv=%b want %h", y_o, y_valid_o, ref_y);
    end
    en = 1'b0;
    repeat (2) step();
    vectors++;
    if ({y_valid_o, data_ready_o} !== 2'b10) begin
      miscompares++; $display("[TB] FAIL stall_done_hold: got yv/rdy=%b want 10", {y_valid_o, data_ready_o});
    end
    en = 1'b1;
    step();
    vectors++;
    if ({y_valid_o, data_ready_o} !== 2'b01) begin
      miscompares++; $display("[TB] FAIL stall_release: got yv/rdy=%b want 01", {y_valid_o, data_ready_o});
    end
    en = 1'b0;
    #1;
    vectors++;
    if (data_ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_idle_ready: got %b want 0", data_ready_o); end
    en = 1'b1;
    step();
    // Spurious product strobe while idle.
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    #1;
    vectors++;
    if ({y_o, y_valid_o, busy_o} !== {ref_y, 2'b00}) begin
      miscompares++; $display("[TB] FAIL spur_idle: got y=%h yv/busy=%b want %h 00", y_o, {y_valid_o, busy_o}, ref_y);
    end
    // Key load attempted while waiting must be ignored.
    old_h = ref_h;
    x = rand128();
    ref_y = gf_mul(ref_y ^ x, ref_h);
    accept_block(x, 1'b0, ok);
    h_i = 128'hFF;
    h_load_i = 1'b1;
    @(negedge clk);
    h_load_i = 1'b0;
    #1;
    wait_y(n);
    vectors++;
    if (y_o !== ref_y) begin miscompares++; $display("[TB] FAIL hload_wait_y: got %h want %h", y_o, ref_y); end
    step();
    x = rand128();
    ref_y = gf_mul(ref_y ^ x, ref_h);
    accept_block(x, 1'b0, ok);
    vectors++;
    if (mul_b_o !== old_h) begin miscompares++; $display("[TB] FAIL hload_wait_h: got %h want %h", mul_b_o, old_h); end
    wait_y(n);
    yv = y_o;
    step();
    vectors++;
    if (yv !== ref_y) begin miscompares++; $display("[TB] FAIL hload_next_y: got %h want %h", yv, ref_y); end
  endtask

  task automatic test_reset_mid_wait();
    logic ok;
    int n;
    logic [127:0] yv;
    lat = 4;
    process_block(rand128(), 1'b0, ok, n, yv);
    accept_block(rand128(), 1'b0, ok);
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if ({mul_valid_o, y_valid_o, busy_o, data_ready_o, mul_a_o, mul_b_o, y_o} !== 388'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_async: got mv=%b yv=%b busy=%b rdy=%b a=%h b=%h y=%h want all 0",
               mul_valid_o, y_valid_o, busy_o, data_ready_o, mul_a_o, mul_b_o, y_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    ref_y = '0; ref_h = '0;
    vectors++;
    if (data_ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_ready: got %b want 1", data_ready_o); end
    load_h(rand128());
    process_block(rand128(), 1'b0, ok, n, yv);
    vectors++;
    if (yv !== ref_y || n !== lat + 1) begin
      miscompares++; $display("[TB] FAIL rst_fresh: got %h n=%0d want %h n=%0d", yv, n, ref_y, lat + 1);
    end
  endtask

  task automatic test_random();
    logic ok;
    int n;
    logic [127:0] yv;
    logic clr;
    for (int k = 0; k < 10; k++) begin
      lat = int'($urandom_range(1, 5));
      if (k % 3 == 0) load_h(rand128());
      clr = ($urandom_range(0, 3) == 0);
      process_block(rand128(), clr, ok, n, yv);
      vectors++;
      if (yv !== ref_y || n !== lat + 1) begin
        miscompares++; $display("[TB] FAIL random_%0d: got %h n=%0d want %h n=%0d", k, yv, n, ref_y, lat + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_reduction();
    test_chaining();
    test_abort();
    test_stall();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ghash_accum.md
# ghash_accum

Sequential GHASH accumulator that feeds the 128-bit carry-less Karatsuba multiplier core and consumes its 256-bit product. For each accepted 128-bit block X it computes Y ← (Y ⊕ X)·H in GF(2^128) modulo x^128 + x^7 + x^2 + x + 1. It issues the operands to the multiplier, waits for the product, folds it down to 128 bits and updates Y. It sits between the GCM datapath (AAD/ciphertext blocks in) and the tag-generation logic (Y out).

## Interface
- WIDTH, 128, operand width; only 128 is supported because the reduction polynomial is fixed.

- clk  in  1  clock; all registers are rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global clock enable, shared with the multiplier; low holds every register.
- h_i  in  128  hash subkey H.
- h_load_i  in  1  loads h_i into the H register; honoured in IDLE only.
- clear_i  in  1  zeroes Y; abort rules below.
- data_valid_i  in  1  block X valid.
- data_i  in  128  block X.
- data_ready_o  out  1  block accepted when data_valid_i & data_ready_o.
- mul_valid_o  out  1  one-cycle operand strobe to the multiplier.
- mul_a_o  out  128  operand Y ⊕ X.
- mul_b_o  out  128  operand H.
- mul_valid_i  in  1  product valid from the multiplier.
- mul_result_i  in  256  carry-less product.
- y_o  out  128  accumulator Y.
- y_valid_o  out  1  one-cycle pulse when Y has absorbed a block.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- Bit convention: bit i is the coefficient of x^i. Callers perform any GCM bit reflection.
- The FSM has four states: IDLE, WAIT, DRAIN and DONE.
- **IDLE**
  - data_ready_o = en & ~rst.
  - On accept, register mul_a_o ← (clear_i ? 0 : Y) ⊕ data_i and mul_b_o ← H, set mul_valid_o for one cycle, then go to WAIT.
- **WAIT**
  - On mul_valid_i, register Y ← reduce(mul_result_i) and go to DONE.
  - If clear_i is high, set Y ← 0 and go to DRAIN.
  - If clear_i and mul_valid_i are high in the same cycle, clear wins: Y ← 0 and go to IDLE with no y_valid_o pulse.
- **DRAIN**: wait for mul_valid_i, discard the product, then go to IDLE. Y does not change.
- **DONE**: y_valid_o = 1 for exactly one cycle, data_ready_o = 0, then go to IDLE.
- **reduce(P)**, with hi = P[255:128] and lo = P[127:0]:
  - t = hi ⊕ (hi<<1) ⊕ (hi<<2) ⊕ (hi<<7), computed at 135 bits.
  - u = t[134:128].
  - result = lo ⊕ t[127:0] ⊕ u ⊕ (u<<1) ⊕ (u<<2) ⊕ (u<<7).
  - No third fold is needed.
- **clear_i in IDLE**: Y ← 0. If a block is accepted in the same cycle, it uses Y = 0.
- **h_load_i**
  - In IDLE it loads H. If a block is accepted in the same cycle, the operands use the old H.
  - In every other state h_load_i is ignored.
- mul_valid_i in IDLE or DONE is ignored.
- **en low**: state and all registers hold, mul_valid_o holds, data_ready_o = 0, y_valid_o holds.

## Timing
- **Reset values**: Y = 0, H = 0, state IDLE, mul_valid_o = 0, mul_a_o = 0, mul_b_o = 0, y_valid_o = 0, data_ready_o = 0, busy_o = 0.
- Throughput is one block per multiplier round-trip; there is no overlap.
- The timeline below assumes en stays high and the multiplier has latency L, measured from mul_valid_o to mul_valid_i.
  - Cycle t: block accepted.
  - Cycle t+1: mul_valid_o = 1.
  - Cycle t+1+L: mul_valid_i = 1.
  - Cycle t+2+L: y_o updated and y_valid_o = 1.
  - Cycle t+3+L: data_ready_o = 1 again.
- busy_o goes high in cycle t+1.
- A clear in WAIT zeroes y_o on the next edge.
- Reset in mid-operation returns to the reset state immediately. The bench also resets the multiplier, so no stale product arrives.

## Test plan
- **Identity key**: reset, H = 1, X = 0x5. Expect mul_a_o = 0x5, mul_b_o = 0x1, y_o = 0x5, a single y_valid_o pulse, and ready back at t+3+L.
- **Reduction**: H = 1<<127, X = 0x2. The product is x^128, so expect y_o = 0x87. Then with Y = 0, H = 1<<127, X = 1<<127, the product is x^254; check y_o against a reference model.
- **Chaining**: H = 0x2. X1 = 0x1 gives y_o = 0x2. X2 = 0x0 gives y_o = 0x4. With clear_i pulsed together with the accept of X3 = 0x1, expect mul_a_o = 0x1.
- **Abort**: accept X = 0xF with H = 1 and pulse clear_i in WAIT. Expect y_o = 0 next cycle, the later product discarded, no y_valid_o pulse, and ready asserted only after mul_valid_i.
- **Stall and spurious inputs**: hold en low for 3 cycles during WAIT and check that all outputs freeze. Drive mul_valid_i in IDLE, and h_load_i in WAIT with h_i = 0xFF. Expect Y and H unchanged.
- **Reset mid-WAIT**: assert rst asynchronously. Expect all outputs at reset values immediately, then a fresh block processed correctly.
